// File: rtl/gray_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : State encoding, luma coefficients and RGB unpack helper for
//               gray_frame_writer.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int c_LUMA_R = 77;
    localparam int c_LUMA_G = 150;
    localparam int c_LUMA_B = 29;

    localparam int c_MAX_CH_W = 16;

    // idx 2 = R, 1 = G, 0 = B of a packed {R,G,B} word with ch_w-bit channels
    function automatic logic [c_MAX_CH_W-1:0] rgb_chan(
        input logic [3*c_MAX_CH_W-1:0] word,
        input int                      ch_w,
        input int                      idx
    );
        logic [c_MAX_CH_W-1:0] res;
        res = '0;
        for (int k = 0; k < c_MAX_CH_W; k++) begin
            if (k < ch_w) res[k] = word[idx*ch_w + k];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_frame_writer_gray_conv.sv
`default_nettype none
// ============================================================================
// Module      : gray_conv
// Description : Combinational RGB -> gray. GRAY_LUMA_EN selects weighted luma,
//               otherwise the (R + 2G + B) >> 2 average.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_conv
    import gray_pkg::*;
#(
    parameter int CH_W = 4
) (
    input  logic [3*CH_W-1:0] rgb,
    output logic [CH_W-1:0]   gray
);

    logic [3*c_MAX_CH_W-1:0] w_word;
    logic [CH_W-1:0]         w_r;
    logic [CH_W-1:0]         w_g;
    logic [CH_W-1:0]         w_b;

    assign w_word = (3*c_MAX_CH_W)'(rgb);
    assign w_r    = CH_W'(rgb_chan(w_word, CH_W, 2));
    assign w_g    = CH_W'(rgb_chan(w_word, CH_W, 1));
    assign w_b    = CH_W'(rgb_chan(w_word, CH_W, 0));

`ifdef GRAY_LUMA_EN
    logic [CH_W+7:0] w_acc;

    assign w_acc = (CH_W+8)'(c_LUMA_R) * (CH_W+8)'(w_r)
                 + (CH_W+8)'(c_LUMA_G) * (CH_W+8)'(w_g)
                 + (CH_W+8)'(c_LUMA_B) * (CH_W+8)'(w_b);
    assign gray  = CH_W'(w_acc >> 8);
`else
    logic [CH_W+1:0] w_sum;

    assign w_sum = (CH_W+2)'(w_r) + (CH_W+2)'({w_g, 1'b0}) + (CH_W+2)'(w_b);
    assign gray  = CH_W'(w_sum >> 2);
`endif

endmodule
`default_nettype wire

// File: rtl/gray_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : gray_frame_writer
// Description : Streams NPIX RGB pixels from a registered source memory through
//               a gray converter into the frame memory at dst_base+i.
//               Macro GRAY_LUMA_EN selects the luma conversion in gray_conv.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_frame_writer
    import gray_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int NPIX   = 1024,
    parameter int CH_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [3*CH_W-1:0] src_data,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [3*CH_W-1:0] dst_data,
    input  logic              dst_ready
);

    localparam logic [ADDR_W:0] c_LAST = (ADDR_W+1)'(NPIX - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_idx1;
    logic              r_v1;
    logic              r_v2;
    logic [ADDR_W-1:0] r_dst_addr;
    logic [3*CH_W-1:0] r_dst_data;
    logic [CH_W-1:0]   w_gray;
    logic              w_stall;
    logic              w_issue;
    logic              w_last_acc;

    // A presented-but-unaccepted write freezes every pipeline stage.
    assign w_stall    = r_v2 && !dst_ready;
    assign w_issue    = (r_state == c_RUN) && !w_stall;
    assign w_last_acc = (r_state == c_DRAIN) && r_v2 && dst_ready && !r_v1;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next = c_RUN;
            c_RUN:   if (w_issue && (r_cnt == c_LAST)) w_next = c_DRAIN;
            c_DRAIN: if (w_last_acc) w_next = c_DONE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        src_rd_en = 1'b0;
        if (r_state != c_IDLE) busy = 1'b1;
        if (r_state == c_DONE) done = 1'b1;
        if (w_issue)           src_rd_en = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_base     <= '0;
            r_idx1     <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_dst_addr <= '0;
            r_dst_data <= '0;
        end else begin
            if ((r_state == c_IDLE) && start) begin
                r_base <= dst_base;
                r_cnt  <= '0;
            end
            if (r_state == c_DONE) r_cnt <= '0;
            if (w_issue) begin
                r_cnt  <= r_cnt + 1'b1;
                r_idx1 <= r_cnt[ADDR_W-1:0];
            end
            if (!w_stall) begin
                r_v1 <= w_issue;
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_dst_addr <= r_base + r_idx1;
                    r_dst_data <= {3{w_gray}};
                end
            end
        end
    end

    gray_conv #(
        .CH_W (CH_W)
    ) u_conv (
        .rgb  (src_data),
        .gray (w_gray)
    );

    assign src_addr  = r_cnt[ADDR_W-1:0];
    assign dst_wr_en = r_v2;
    assign dst_addr  = r_dst_addr;
    assign dst_data  = r_dst_data;

endmodule
`default_nettype wire

// File: tb/tb_gray_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_frame_writer
// Description : Scoreboard bench for gray_frame_writer (NPIX=16 and NPIX=1024).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_frame_writer;

    typedef struct packed {
        logic [9:0]  addr;
        logic [11:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_start = 1'b0, a_rdy = 1'b1, a_busy, a_done, a_rd, a_wr;
    logic [9:0]  a_base = '0, a_src_addr, a_dst_addr;
    logic [11:0] a_src_data = '0, a_dst_data;
    logic        b_start = 1'b0, b_rdy = 1'b1, b_busy, b_done, b_rd, b_wr;
    logic [9:0]  b_base = '0, b_src_addr, b_dst_addr;
    logic [11:0] b_src_data = '0, b_dst_data;

    int   a_mode = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0, n_fail = 0;
    int   a_acc = 0, a_ndone = 0, b_acc = 0;
    logic [9:0]  b_last_src = '0;
    logic        a_prev_stall = 1'b0;
    logic [9:0]  a_prev_addr = '0;
    logic [11:0] a_prev_data = '0;

    gray_frame_writer #(.ADDR_W(10), .NPIX(16), .CH_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .dst_base(a_base),
        .busy(a_busy), .done(a_done), .src_rd_en(a_rd), .src_addr(a_src_addr),
        .src_data(a_src_data), .dst_wr_en(a_wr), .dst_addr(a_dst_addr),
        .dst_data(a_dst_data), .dst_ready(a_rdy)
    );

    gray_frame_writer #(.ADDR_W(10), .NPIX(1024), .CH_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .dst_base(b_base),
        .busy(b_busy), .done(b_done), .src_rd_en(b_rd), .src_addr(b_src_addr),
        .src_data(b_src_data), .dst_wr_en(b_wr), .dst_addr(b_dst_addr),
        .dst_data(b_dst_data), .dst_ready(b_rdy)
    );

    function automatic logic [11:0] pat(input int mode, input logic [9:0] a);
        if (mode == 1) return 12'hF00;
        return {a[3:0], a[3:0], a[3:0]};
    endfunction

    function automatic logic [3:0] model_gray(input logic [11:0] p);
        int r, g, b;
        r = int'(p[11:8]);
        g = int'(p[7:4]);
        b = int'(p[3:0]);
`ifdef GRAY_LUMA_EN
        return 4'((77*r + 150*g + 29*b) >> 8);
`else
        return 4'((r + 2*g + b) >> 2);
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered-output source memories; data held while read enable is low.
    always @(posedge clk) if (a_rd) a_src_data <= pat(a_mode, a_src_addr);
    always @(posedge clk) if (b_rd) b_src_data <= pat(0, b_src_addr);

    always @(negedge clk) begin
        exp_t e;
        if (rst && a_wr && a_rdy) begin
            a_acc++;
            if (q_a.size() == 0) chk("a_unexpected_write", a_wr, 1'b0);
            else begin
                e = q_a.pop_front();
                chk("a_dst_addr", a_dst_addr, e.addr);
                chk("a_dst_data", a_dst_data, e.data);
            end
        end
        if (rst && a_prev_stall) begin
            chk("a_hold_wr_en", a_wr, 1'b1);
            chk("a_hold_addr", a_dst_addr, a_prev_addr);
            chk("a_hold_data", a_dst_data, a_prev_data);
        end
        if (rst && a_wr && !a_rdy) chk("a_stall_rd_en", a_rd, 1'b0);
        a_prev_stall = rst && a_wr && !a_rdy;
        a_prev_addr  = a_dst_addr;
        a_prev_data  = a_dst_data;
        if (rst && a_done) a_ndone++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && b_rd) b_last_src = b_src_addr;
        if (rst && b_wr && b_rdy) begin
            b_acc++;
            if (q_b.size() == 0) chk("b_unexpected_write", b_wr, 1'b0);
            else begin
                e = q_b.pop_front();
                chk("b_dst_addr", b_dst_addr, e.addr);
                chk("b_dst_data", b_dst_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [9:0] base, input int mode);
        exp_t e;
        a_mode = mode;
        for (int i = 0; i < 16; i++) begin
            e.addr = base + 10'(i);
            e.data = {3{model_gray(pat(mode, 10'(i)))}};
            q_a.push_back(e);
        end
        a_base  = base;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic wait_a(input bit toggle, output int cyc);
        cyc = 1;
        for (int k = 0; k < 400; k++) begin
            if (toggle) a_rdy = ~a_rdy;
            tick();
            cyc++;
            if (a_done) break;
        end
        chk("a_done_seen", a_done, 1'b1);
    endtask

    task automatic after_a();
        tick();
        chk("a_done_pulse", a_done, 1'b0);
        chk("a_busy_idle", a_busy, 1'b0);
        chk("a_queue_empty", q_a.size(), 0);
    endtask

    initial begin
        int cyc, acc0, nd0;
        exp_t e;

        rst = 1'b0;
        tick();
        tick();
        chk("reset_outs_a", {a_busy, a_done, a_rd, a_src_addr, a_wr, a_dst_addr, a_dst_data}, 0);
        chk("reset_outs_b", {b_busy, b_done, b_rd, b_src_addr, b_wr, b_dst_addr, b_dst_data}, 0);
        rst = 1'b1;
        tick();

        // Identity pixels, base 0, sink always ready.
        start_a(10'h000, 0);
        chk("a_busy_accept", a_busy, 1'b1);
        chk("a_first_issue", {a_rd, a_src_addr}, {1'b1, 10'h000});
        wait_a(1'b0, cyc);
        chk("a_done_latency", cyc, 19);
        after_a();

        // Pure red pixels.
        start_a(10'h000, 1);
        wait_a(1'b0, cyc);
        after_a();

        // Destination address wraps past 0x3FF.
        start_a(10'h3FA, 0);
        wait_a(1'b0, cyc);
        chk("a_wrap_latency", cyc, 19);
        after_a();

        // Stall on the 3rd write for 5 cycles, then ready toggles every cycle.
        acc0 = a_acc;
        start_a(10'h000, 0);
        for (int k = 0; k < 50 && !(a_acc == acc0 + 2 && a_wr); k++) tick();
        chk("a_third_write_seen", a_wr, 1'b1);
        a_rdy = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        wait_a(1'b1, cyc);
        a_rdy = 1'b1;
        after_a();
        chk("a_stall_write_count", a_acc - acc0, 16);

        // Start re-pulsed mid-frame is ignored.
        nd0 = a_ndone;
        start_a(10'h000, 0);
        tick();
        tick();
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_a(1'b0, cyc);
        after_a();
        tick();
        chk("a_single_done", a_ndone - nd0, 1);

        // Reset while the 7th write is presented aborts the frame.
        acc0 = a_acc;
        start_a(10'h000, 0);
        for (int k = 0; k < 50 && !(a_acc == acc0 + 6 && a_wr); k++) tick();
        chk("a_seventh_write_seen", a_wr, 1'b1);
        rst = 1'b0;
        tick();
        chk("a_abort_outs", {a_busy, a_done, a_rd, a_src_addr, a_wr, a_dst_addr, a_dst_data}, 0);
        q_a.delete();
        nd0  = a_ndone;
        acc0 = a_acc;
        rst  = 1'b1;
        for (int k = 0; k < 25; k++) tick();
        chk("a_no_done_after_abort", a_ndone, nd0);
        chk("a_no_write_after_abort", a_acc, acc0);

        start_a(10'h000, 0);
        wait_a(1'b0, cyc);
        chk("a_post_abort_latency", cyc, 19);
        after_a();

        // Full 1024-pixel frame.
        for (int i = 0; i < 1024; i++) begin
            e.addr = 10'(i);
            e.data = {3{model_gray(pat(0, 10'(i)))}};
            q_b.push_back(e);
        end
        acc0    = b_acc;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 1100; k++) begin
            tick();
            cyc++;
            if (b_done) break;
        end
        chk("b_done_seen", b_done, 1'b1);
        chk("b_done_latency", cyc, 1027);
        tick();
        chk("b_busy_idle", b_busy, 1'b0);
        chk("b_queue_empty", q_b.size(), 0);
        chk("b_last_src_addr", b_last_src, 10'h3FF);
        chk("b_write_count", b_acc - acc0, 1024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
